jk_counter_n: RTL and testbench
===============================

JK_COUNTER_N -- requirements
Module: jk_counter_n

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, range 2..16.
REQ-002 Parameter MODULUS, default 16: count range 0..MODULUS-1, with 2 <= MODULUS <= 2**WIDTH.
REQ-003 clk  input  1  rising-edge clock; the block's only clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  count/load enable, sampled on the rising clk edge.
REQ-006 clr  input  1  synchronous clear; highest-priority synchronous control.
REQ-007 mode  input  2  JK-style control: 00 hold, 01 count down, 10 count up, 11 load.
REQ-008 d  input  WIDTH  parallel load value, used when mode=11.
REQ-009 q  output  WIDTH  registered count value.
REQ-010 tc  output  1  combinational terminal count.
REQ-011 wrap  output  1  registered one-cycle pulse marking the cycle after a wrap-around.

Function
REQ-012 All state changes except reset shall occur on the rising clk edge only.
REQ-013 Priority per edge: rst_n low first, then clr=1, then en=0, then mode.
REQ-014 clr=1 (en ignored): next q=0 and next wrap=0.
REQ-015 en=0 with clr=0: q holds and next wrap=0.
REQ-016 en=1, mode=00: q holds and next wrap=0.
REQ-017 en=1, mode=10, q<MODULUS-1: q increments by 1 and next wrap=0.
REQ-018 en=1, mode=10, q=MODULUS-1: q becomes 0 and next wrap=1.
REQ-019 en=1, mode=01, q>0: q decrements by 1 and next wrap=0.
REQ-020 en=1, mode=01, q=0: q becomes MODULUS-1 and next wrap=1.
REQ-021 en=1, mode=11, d<MODULUS: q loads d and next wrap=0.
REQ-022 en=1, mode=11, d>=MODULUS: q loads 0 (out-of-range clamp) and next wrap=0.
REQ-023 tc shall be 1 when en=1 and either mode=10 with q=MODULUS-1, or mode=01 with q=0; otherwise tc shall be 0.
REQ-024 tc shall be forced to 0 while clr=1 or rst_n=0.
REQ-025 wrap shall stay high for exactly one cycle per wrap event; back-to-back wraps (e.g. MODULUS=2 counting continuously) shall keep wrap high on consecutive cycles.
REQ-026 Changing mode between up and down mid-count shall take effect on the next edge with no lost or extra step.
REQ-027 Count arithmetic shall be performed modulo MODULUS in WIDTH bits.
REQ-028 q shall never hold a value >= MODULUS after reset has been applied once.
REQ-029 Each bit of q shall be implemented as a JK flip-flop cell; J/K next-state logic shall be derived per bit from mode and the current count.

Reset
REQ-030 rst_n=0 shall force q=0 and wrap=0 immediately, independent of clk.
REQ-031 While rst_n=0, q shall hold 0 and all synchronous inputs shall be ignored.
REQ-032 Deasserting rst_n mid-operation shall take effect cleanly: the first rising edge after release shall act on the inputs present at that edge.

Verification
REQ-033 The bench shall use WIDTH=4 and MODULUS=10, and shall cover at least the following directed scenarios.
REQ-034 Reset then up-count: rst_n low, then high; en=1, mode=10 for 12 edges -> q sequence 1..9,0,1,2; tc=1 while q=9; wrap=1 only on the cycle where q=0 after the wrap.
REQ-035 Down-count from reset: q=0, en=1, mode=01 -> q=9 after the first edge and wrap=1 for one cycle; tc=1 before that edge.
REQ-036 Load with clamp: mode=11, d=7 -> q=7; then d=12 -> q=0; wrap stays 0 throughout.
REQ-037 Priority: clr=1 with en=1, mode=10, q=9 -> q=0 and wrap=0; en=0 with mode=10 -> q holds and tc=0.
REQ-038 Asynchronous reset: pull rst_n low between clock edges while q=5 -> q=0 before the next edge; release mid-cycle, then up-count -> q=1 on the first edge after release.
REQ-039 Direction change: counting up at q=4, switch to mode=01 -> q=3 on the next edge with no skipped or repeated value.

Source files
------------

// File: rtl/jk_counter_n.sv
// Modulo-MODULUS up/down/load counter whose state bits are JK flip-flop cells.
// tc flags the edge that will wrap; wrap pulses in the cycle after a wrap.
module jk_counter_n #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_UP   = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

  // Characteristic equation of a JK flip-flop: Q+ = J.~Q + ~K.Q
  function automatic logic jk_cell(input logic j, input logic k, input logic qb);
    return (j & ~qb) | (~k & qb);
  endfunction

  logic [WIDTH-1:0] cnt_q, cnt_d, target, j_vec, k_vec;
  logic             wrap_q, wrap_d;

  always_comb begin
    target = cnt_q;
    wrap_d = 1'b0;
    if (clr) begin
      target = '0;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_UP: begin
          if (cnt_q == MAX_Q) begin
            target = '0;
            wrap_d = 1'b1;
          end else begin
            target = cnt_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (cnt_q == '0) begin
            target = MAX_Q;
            wrap_d = 1'b1;
          end else begin
            target = cnt_q - WIDTH'(1);
          end
        end
        MODE_LOAD: target = ({1'b0, d} < MOD_X) ? d : '0;
        default:   target = cnt_q;
      endcase
    end
  end

  // Per-bit J sets a bit that must rise, K clears a bit that must fall.
  always_comb begin
    j_vec = ~cnt_q & target;
    k_vec = cnt_q & ~target;
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = jk_cell(j_vec[i], k_vec[i], cnt_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = cnt_q;
  assign wrap = wrap_q;
  assign tc   = rst_n & ~clr & en &
                (((mode == MODE_UP) && (cnt_q == MAX_Q)) ||
                 ((mode == MODE_DOWN) && (cnt_q == '0)));

endmodule

// File: tb/tb_jk_counter_n.sv
// Directed scenarios for jk_counter_n (WIDTH=4, MODULUS=10) with a queue of
// expected {q, wrap} values filled at drive time and drained after each edge.
module tb_jk_counter_n;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;

  typedef struct packed {
    logic [W-1:0] q;
    logic         wrap;
  } exp_t;

  exp_t         sb[$];
  exp_t         ex;
  logic [W-1:0] model_q;
  int           total = 0;
  int           bad = 0;

  jk_counter_n #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
    .d(d), .q(q), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish before it");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [W-1:0] cq, input logic e, input logic c,
                                 input logic [1:0] m, input logic [W-1:0] dd);
    exp_t r;
    r.q = cq;
    r.wrap = 1'b0;
    if (c) r.q = '0;
    else if (e) begin
      if (m == 2'b10) begin
        if (int'(cq) == M - 1) begin r.q = '0; r.wrap = 1'b1; end
        else r.q = W'(int'(cq) + 1);
      end else if (m == 2'b01) begin
        if (cq == '0) begin r.q = W'(M - 1); r.wrap = 1'b1; end
        else r.q = W'(int'(cq) - 1);
      end else if (m == 2'b11) begin
        r.q = (int'(dd) < M) ? dd : '0;
      end
    end
    return r;
  endfunction

  function automatic logic model_tc(input logic [W-1:0] cq, input logic e, input logic c,
                                    input logic [1:0] m);
    if (c || !e) return 1'b0;
    return ((m == 2'b10) && (int'(cq) == M - 1)) || ((m == 2'b01) && (cq == '0));
  endfunction

  task automatic set_in(input logic e, input logic c, input logic [1:0] m, input logic [W-1:0] dd);
    en = e; clr = c; mode = m; d = dd;
    #1;
  endtask

  task automatic clock_edge();
    exp_t r;
    r = model(model_q, en, clr, mode, d);
    sb.push_back(r);
    model_q = r.q;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b0, 2'b01, '0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (q !== '0) begin bad++; $display("FAIL reset_q: got %0d expected 0", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc: got %0b expected 0", tc); end
    #2 rst_n = 1'b1;
    model_q = '0;
  endtask

  task automatic test_up_count();
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, 1'b0, 2'b10, '0);
      total++;
      if (tc !== model_tc(model_q, en, clr, mode)) begin
        bad++; $display("FAIL up_tc[%0d]: got %0b expected %0b", i, tc, model_tc(model_q, en, clr, mode));
      end
      clock_edge();
      ex = sb.pop_front();
      total++; if (q !== ex.q) begin bad++; $display("FAIL up_q[%0d]: got %0d expected %0d", i, q, ex.q); end
      total++; if (wrap !== ex.wrap) begin bad++; $display("FAIL up_wrap[%0d]: got %0b expected %0b", i, wrap, ex.wrap); end
    end
  endtask

  task automatic test_down_count();
    set_in(1'b1, 1'b1, 2'b10, '0);
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL clr_tc: got %0b expected 0", tc); end
    clock_edge();
    ex = sb.pop_front();
    total++; if (q !== ex.q) begin bad++; $display("FAIL clr_q: got %0d expected %0d", q, ex.q); end
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 2'b01, '0);
      total++;
      if (tc !== model_tc(model_q, en, clr, mode)) begin
        bad++; $display("FAIL down_tc[%0d]: got %0b expected %0b", i, tc, model_tc(model_q, en, clr, mode));
      end
      clock_edge();
      ex = sb.pop_front();
      total++; if (q !== ex.q) begin bad++; $display("FAIL down_q[%0d]: got %0d expected %0d", i, q, ex.q); end
      total++; if (wrap !== ex.wrap) begin bad++; $display("FAIL down_wrap[%0d]: got %0b expected %0b", i, wrap, ex.wrap); end
    end
  endtask

  task automatic test_load();
    logic [W-1:0] vals [3] = '{4'd7, 4'd12, 4'd9};
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 2'b11, vals[i]);
      clock_edge();
      ex = sb.pop_front();
      total++; if (q !== ex.q) begin bad++; $display("FAIL load_q[%0d]: got %0d expected %0d", i, q, ex.q); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL load_wrap[%0d]: got %0b expected 0", i, wrap); end
    end
  endtask

  task automatic test_priority();
    set_in(1'b1, 1'b1, 2'b10, '0);
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL prio_clr_tc: got %0b expected 0", tc); end
    clock_edge();
    ex = sb.pop_front();
    total++; if (q !== ex.q) begin bad++; $display("FAIL prio_clr_q: got %0d expected %0d", q, ex.q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL prio_clr_wrap: got %0b expected 0", wrap); end
    set_in(1'b1, 1'b0, 2'b11, 4'd9);
    clock_edge();
    ex = sb.pop_front();
    set_in(1'b0, 1'b0, 2'b10, '0);
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL prio_en_tc: got %0b expected 0", tc); end
    clock_edge();
    ex = sb.pop_front();
    total++; if (q !== ex.q) begin bad++; $display("FAIL prio_en_q: got %0d expected %0d", q, ex.q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL prio_en_wrap: got %0b expected 0", wrap); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] modes [4] = '{2'b10, 2'b01, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, modes[i], '0);
      clock_edge();
      ex = sb.pop_front();
      total++; if (q !== ex.q) begin bad++; $display("FAIL b2b_q[%0d]: got %0d expected %0d", i, q, ex.q); end
      total++; if (wrap !== ex.wrap) begin bad++; $display("FAIL b2b_wrap[%0d]: got %0b expected %0b", i, wrap, ex.wrap); end
    end
  endtask

  task automatic test_async_reset();
    set_in(1'b1, 1'b0, 2'b11, 4'd5);
    clock_edge();
    ex = sb.pop_front();
    total++; if (q !== ex.q) begin bad++; $display("FAIL arst_pre_q: got %0d expected %0d", q, ex.q); end
    set_in(1'b1, 1'b0, 2'b10, '0);
    #1 rst_n = 1'b0;
    #1;
    total++; if (q !== '0) begin bad++; $display("FAIL arst_imm_q: got %0d expected 0", q); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL arst_tc: got %0b expected 0", tc); end
    @(posedge clk);
    #1;
    total++; if (q !== '0) begin bad++; $display("FAIL arst_hold_q: got %0d expected 0", q); end
    #3 rst_n = 1'b1;
    model_q = '0;
    set_in(1'b1, 1'b0, 2'b10, '0);
    clock_edge();
    ex = sb.pop_front();
    total++; if (q !== ex.q) begin bad++; $display("FAIL arst_release_q: got %0d expected %0d", q, ex.q); end
  endtask

  task automatic test_direction();
    logic [1:0] modes [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, modes[i], '0);
      clock_edge();
      ex = sb.pop_front();
      total++; if (q !== ex.q) begin bad++; $display("FAIL dir_q[%0d]: got %0d expected %0d", i, q, ex.q); end
      total++; if (wrap !== ex.wrap) begin bad++; $display("FAIL dir_wrap[%0d]: got %0b expected %0b", i, wrap, ex.wrap); end
    end
  endtask

  initial begin
    model_q = '0;
    test_reset();
    test_up_count();
    test_down_count();
    test_load();
    test_priority();
    test_back_to_back();
    test_async_reset();
    test_direction();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
